// File: rtl/mem_wb_pkg.sv
// Shared write-back definitions: load type encodings
// and default datapath widths for the MEM/WB boundary.
package mem_wb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;
  localparam int CNT_W_DEF  = 32;

  localparam int LOAD_TW = 3;

  localparam logic [LOAD_TW-1:0] LOAD_NONE = 3'd0;
  localparam logic [LOAD_TW-1:0] LOAD_LB   = 3'd1;
  localparam logic [LOAD_TW-1:0] LOAD_LBU  = 3'd2;
  localparam logic [LOAD_TW-1:0] LOAD_LH   = 3'd3;
  localparam logic [LOAD_TW-1:0] LOAD_LHU  = 3'd4;
  localparam logic [LOAD_TW-1:0] LOAD_LW   = 3'd5;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Little-endian load formatter and misaligned-load
// detector, purely combinational on the MEM side.
module mem_wb_stage_load_align
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [LOAD_TW-1:0] ltype,
  input  logic [1:0]         off,
  input  logic [DATA_W-1:0]  rdata,
  input  logic [DATA_W-1:0]  alu_result,
  output logic [DATA_W-1:0]  data,
  output logic               adel
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = rdata[{off, 3'b000} +: 8];
  assign h = rdata[{off[1], 4'b0000} +: 16];

  always_comb begin
    data = alu_result;
    adel = 1'b0;
    unique case (1'b1)
      (ltype == LOAD_LB):
        data = {{(DATA_W-8){b[7]}}, b};
      (ltype == LOAD_LBU):
        data = {{(DATA_W-8){1'b0}}, b};
      (ltype == LOAD_LH): begin
        data = {{(DATA_W-16){h[15]}}, h};
        adel = off[0];
      end
      (ltype == LOAD_LHU): begin
        data = {{(DATA_W-16){1'b0}}, h};
        adel = off[0];
      end
      (ltype == LOAD_LW): begin
        data = rdata;
        adel = (off != 2'b00);
      end
      default: data = alu_result;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: formats loads, drives the
// register file write port and counts retirements.
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               mem_valid,
  input  logic               mem_wreg,
  input  logic [REG_AW-1:0]  mem_wreg_addr,
  input  logic [DATA_W-1:0]  mem_alu_result,
  input  logic [2:0]         mem_load_type,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic [DATA_W-1:0]  mem_pc,
  output logic               wb_we,
  output logic [REG_AW-1:0]  wb_rw,
  output logic [DATA_W-1:0]  wb_rd,
  output logic               wb_valid,
  output logic [DATA_W-1:0]  wb_pc,
  output logic               wb_adel,
  output logic [CNT_W-1:0]   retire_cnt
);

  logic [DATA_W-1:0] fmt_data;
  logic              fmt_adel;
  logic              wreg_q;

  mem_wb_stage_load_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .ltype      (mem_load_type),
    .off        (mem_alu_result[1:0]),
    .rdata      (mem_rdata),
    .alu_result (mem_alu_result),
    .data       (fmt_data),
    .adel       (fmt_adel)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid   <= 1'b0;
      wreg_q     <= 1'b0;
      wb_rw      <= '0;
      wb_rd      <= '0;
      wb_pc      <= '0;
      wb_adel    <= 1'b0;
      retire_cnt <= '0;
    end else if (flush) begin
      wb_valid <= 1'b0;
      wb_adel  <= 1'b0;
    end else if (!stall) begin
      wb_valid <= mem_valid;
      wreg_q   <= mem_wreg & ~fmt_adel;
      wb_rw    <= mem_wreg_addr;
      wb_rd    <= fmt_data;
      wb_pc    <= mem_pc;
      wb_adel  <= mem_valid & fmt_adel;
      if (mem_valid && !fmt_adel)
        retire_cnt <= retire_cnt + 1'b1;
    end
  end

  // x0 is never written, so suppress the strobe for it
  assign wb_we = wb_valid & wreg_q & (wb_rw != '0);

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: load formatting,
// stall/flush priority, reset and counter wrap.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic        mem_wreg;
  logic [4:0]  mem_wreg_addr;
  logic [31:0] mem_alu_result;
  logic [2:0]  mem_load_type;
  logic [31:0] mem_rdata;
  logic [31:0] mem_pc;
  logic        wb_we;
  logic [4:0]  wb_rw;
  logic [31:0] wb_rd;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        wb_adel;
  logic [3:0]  retire_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(
    .DATA_W(32),
    .REG_AW(5),
    .CNT_W (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .mem_valid      (mem_valid),
    .mem_wreg       (mem_wreg),
    .mem_wreg_addr  (mem_wreg_addr),
    .mem_alu_result (mem_alu_result),
    .mem_load_type  (mem_load_type),
    .mem_rdata      (mem_rdata),
    .mem_pc         (mem_pc),
    .wb_we          (wb_we),
    .wb_rw          (wb_rw),
    .wb_rd          (wb_rd),
    .wb_valid       (wb_valid),
    .wb_pc          (wb_pc),
    .wb_adel        (wb_adel),
    .retire_cnt     (retire_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
  endtask

  task automatic drive(input logic v,
                       input logic wr,
                       input logic [4:0] a,
                       input logic [31:0] alu,
                       input logic [2:0] ty,
                       input logic [31:0] rd);
    mem_valid      = v;
    mem_wreg       = wr;
    mem_wreg_addr  = a;
    mem_alu_result = alu;
    mem_load_type  = ty;
    mem_rdata      = rd;
    mem_pc         = mem_pc + 32'd4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    mem_pc = 32'h0000_1000;
    drive(0, 0, 5'd0, 32'h0, 3'd0, 32'h0);
    #12;
    chk("rst_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_we", {31'b0, wb_we}, 32'd0);
    chk("rst_rd", wb_rd, 32'd0);
    chk("rst_pc", wb_pc, 32'd0);
    chk("rst_cnt", {28'b0, retire_cnt}, 32'd0);
    reset = 1'b1;

    drive(1, 1, 5'd5, 32'h0000_1234, 3'd0, 32'h0);
    tick();
    chk("alu_we", {31'b0, wb_we}, 32'd1);
    chk("alu_rw", {27'b0, wb_rw}, 32'd5);
    chk("alu_rd", wb_rd, 32'h0000_1234);
    chk("alu_pc", wb_pc, 32'h0000_1008);
    chk("alu_cnt", {28'b0, retire_cnt}, 32'd1);

    drive(1, 1, 5'd6, 32'h0000_1003, 3'd1, 32'h80FF_7F01);
    tick();
    chk("lb3_rd", wb_rd, 32'hFFFF_FF80);
    chk("lb3_cnt", {28'b0, retire_cnt}, 32'd2);

    drive(1, 1, 5'd6, 32'h0000_1003, 3'd2, 32'h80FF_7F01);
    tick();
    chk("lbu3_rd", wb_rd, 32'h0000_0080);

    drive(1, 1, 5'd6, 32'h0000_1001, 3'd1, 32'h80FF_7F01);
    tick();
    chk("lb1_rd", wb_rd, 32'h0000_007F);
    chk("lb1_cnt", {28'b0, retire_cnt}, 32'd4);

    drive(1, 1, 5'd8, 32'h0000_1002, 3'd3, 32'h8001_0000);
    tick();
    chk("lh2_rd", wb_rd, 32'hFFFF_8001);
    chk("lh2_adel", {31'b0, wb_adel}, 32'd0);
    chk("lh2_cnt", {28'b0, retire_cnt}, 32'd5);

    drive(1, 1, 5'd8, 32'h0000_1002, 3'd5, 32'h8001_0000);
    tick();
    chk("lw2_adel", {31'b0, wb_adel}, 32'd1);
    chk("lw2_we", {31'b0, wb_we}, 32'd0);
    chk("lw2_cnt", {28'b0, retire_cnt}, 32'd5);

    drive(1, 1, 5'd8, 32'h0000_1001, 3'd4, 32'h8001_0000);
    tick();
    chk("lhu1_adel", {31'b0, wb_adel}, 32'd1);
    chk("lhu1_cnt", {28'b0, retire_cnt}, 32'd5);

    drive(1, 1, 5'd7, 32'h0000_00AA, 3'd0, 32'h0);
    tick();
    chk("cap_adel", {31'b0, wb_adel}, 32'd0);
    chk("cap_we", {31'b0, wb_we}, 32'd1);
    chk("cap_cnt", {28'b0, retire_cnt}, 32'd6);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 5'd9 + 5'(i), 32'h55 + 32'(i), 3'd0, 32'h0);
      tick();
      chk("stl_rw", {27'b0, wb_rw}, 32'd7);
      chk("stl_rd", wb_rd, 32'h0000_00AA);
      chk("stl_we", {31'b0, wb_we}, 32'd1);
      chk("stl_cnt", {28'b0, retire_cnt}, 32'd6);
    end

    flush = 1'b1;
    tick();
    chk("sf_valid", {31'b0, wb_valid}, 32'd0);
    chk("sf_we", {31'b0, wb_we}, 32'd0);
    chk("sf_cnt", {28'b0, retire_cnt}, 32'd6);
    stall = 1'b0;
    flush = 1'b0;

    drive(1, 1, 5'd0, 32'h0000_0042, 3'd0, 32'h0);
    tick();
    chk("r0_valid", {31'b0, wb_valid}, 32'd1);
    chk("r0_we", {31'b0, wb_we}, 32'd0);
    chk("r0_cnt", {28'b0, retire_cnt}, 32'd7);

    drive(0, 1, 5'd4, 32'h0000_0042, 3'd0, 32'h0);
    tick();
    chk("bub_valid", {31'b0, wb_valid}, 32'd0);
    chk("bub_we", {31'b0, wb_we}, 32'd0);
    chk("bub_cnt", {28'b0, retire_cnt}, 32'd7);

    drive(1, 1, 5'd3, 32'h0000_0077, 3'd0, 32'h0);
    tick();
    chk("pre_we", {31'b0, wb_we}, 32'd1);
    chk("pre_cnt", {28'b0, retire_cnt}, 32'd8);
    stall = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("ar_valid", {31'b0, wb_valid}, 32'd0);
    chk("ar_we", {31'b0, wb_we}, 32'd0);
    chk("ar_rw", {27'b0, wb_rw}, 32'd0);
    chk("ar_rd", wb_rd, 32'd0);
    chk("ar_cnt", {28'b0, retire_cnt}, 32'd0);
    #2;
    reset = 1'b1;
    stall = 1'b0;

    drive(1, 1, 5'd1, 32'h0000_0010, 3'd0, 32'h0);
    for (int i = 0; i < 15; i++) tick();
    chk("wrap15", {28'b0, retire_cnt}, 32'd15);
    tick();
    chk("wrap0", {28'b0, retire_cnt}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Pipeline register and write-back formatter between the MEM stage and the register file.
- Captures MEM results once per clock and formats load data (byte/half/word, signed/unsigned, little-endian).
- Drives the register file write port (we, rw, rd) and a same-cycle forwarding copy for the ID/EX bypass logic.
- Detects misaligned loads and counts retired instructions.

Parameters:
- DATA_W, 32, datapath width (`DataBus).
- REG_AW, 5, register address width (`DecodeRegBus).
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hold the WB register contents.
- flush  in  1  kill the entry being captured.
- mem_valid  in  1  MEM holds a real instruction.
- mem_wreg  in  1  instruction writes a GPR.
- mem_wreg_addr  in  REG_AW  destination register.
- mem_alu_result  in  DATA_W  ALU result, or effective address for loads.
- mem_load_type  in  3  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW; 6–7 reserved and treated as NONE.
- mem_rdata  in  DATA_W  raw aligned word from data memory, valid combinationally in the MEM cycle.
- mem_pc  in  DATA_W  PC of the MEM instruction.
- wb_we  out  1  register file write enable.
- wb_rw  out  REG_AW  register file write address.
- wb_rd  out  DATA_W  register file write data.
- wb_valid  out  1  WB holds a real instruction.
- wb_pc  out  DATA_W  PC of the WB instruction.
- wb_adel  out  1  misaligned-load exception flag for the WB instruction.
- retire_cnt  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (reset=0, asynchronous), all registered state cleared: wb_valid=0, wb_rw=0, wb_rd=0, wb_pc=0, wb_adel=0, retire_cnt=0. Hence wb_we=0.
- Reset mid-stream discards the in-flight entry with no register file write.
- Latency: exactly 1 cycle from MEM inputs to WB outputs. No combinational path from mem_* to wb_*.
- Register update priority at each rising clk edge:
  - flush=1: wb_valid<=0, wb_adel<=0, other fields don't-care (hold). Flush takes priority over stall.
  - else stall=1: all WB registers hold. retire_cnt holds.
  - else: capture formatted MEM data. wb_valid<=mem_valid.
- Load formatting (combinational, MEM side, before the register), with off = mem_alu_result[1:0], little-endian:
  - LB: byte mem_rdata[8*off+7:8*off], sign-extended.
  - LBU: same byte, zero-extended.
  - LH: half selected by off[1], sign-extended.
  - LHU: same half, zero-extended.
  - LW: mem_rdata unchanged.
  - NONE: mem_alu_result.
- Misalignment:
  - LH or LHU with off[0]=1, or LW with off!=0, sets adel=1.
  - Captured as wb_adel <= mem_valid & adel.
  - On adel the write is suppressed: the captured wreg bit is forced to 0.
- Write enable: wb_we = wb_valid & wreg_q & (wb_rw != 0), combinational from registered state.
  - wb_we stays asserted while stall holds a valid entry. The register file rewrites the same value, which is harmless.
- wb_rd and wb_rw are the registered values. wb_rd=0 for register 0 is not required; the register file ignores writes to register 0.
- retire_cnt increments by 1 on each non-stalled, non-flushed edge where mem_valid=1 and adel=0.
  - Wraps from 2^CNT_W−1 to 0 with no flag.
- Simultaneous stall and flush: flush wins; the counter does not increment.
- wb_adel is a level signal that lasts while the entry is held. The exception unit clears it via flush.

Decomposition:
- Shared include stddef.v gains:
  - load type encodings LOAD_NONE, LOAD_LB, LOAD_LBU, LOAD_LH, LOAD_LHU, LOAD_LW;
  - a `LoadTypeBus 2:0 define.
  - It reuses the existing `DataBus, `DecodeRegBus and `DataInit defines.
- One natural sub-module: load_align, the purely combinational formatter and misalignment detector (inputs: type, off, rdata, alu_result; outputs: data, adel).
- The stage module holds the pipeline register, priority logic and counter.

Test Plan:
- ALU pass-through: mem_valid=1, wreg=1, addr=5, type NONE, alu=0x0000_1234, no stall or flush. Next cycle: wb_we=1, wb_rw=5, wb_rd=0x0000_1234, retire_cnt=1.
- Byte loads: rdata=0x80FF_7F01, type LB, off=3. Required wb_rd=0xFFFF_FF80. Same with LBU gives 0x0000_0080. LB with off=1 gives 0x0000_007F.
- Half loads and misalignment:
  - LH, off=2, rdata=0x8001_0000: wb_rd=0xFFFF_8001.
  - LW, off=2: wb_adel=1, wb_we=0, retire_cnt unchanged.
  - LHU, off=1: wb_adel=1.
- Stall/flush:
  - Capture addr=7, data=0xAA. Assert stall for 3 cycles while changing MEM inputs: wb_rw=7 and wb_rd=0xAA hold, wb_we=1 throughout.
  - Then stall=1 and flush=1 together: wb_valid=0, wb_we=0, counter unchanged.
- Register 0 and bubbles:
  - addr=0, wreg=1: wb_we=0, counter still increments.
  - mem_valid=0: wb_valid=0, no increment.
- Reset and wrap:
  - Pull reset low asynchronously mid-cycle with a valid entry held: outputs clear immediately, before the next edge.
  - With CNT_W=4, 16 retirements give retire_cnt wrapping 15→0.
